// File: rtl/mac_pkg.sv
// Shared definitions for the dot-product MAC sequencer: FSM encoding and the
// sign-magnitude saturate/canonicalise helper.
package mac_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_RESULT = 3'd4
  } state_e;

  // Wide enough for any accumulator width this block is built with.
  localparam int SM_MAX_W = 64;

  // Returns {sign, magnitude}; a zero magnitude always carries sign 0.
  function automatic logic [SM_MAX_W:0] sm_sat_canon(
    input logic                sgn,
    input logic                ovf,
    input logic [SM_MAX_W-1:0] mag,
    input logic [SM_MAX_W-1:0] sat_mag
  );
    logic [SM_MAX_W-1:0] m;
    m = ovf ? sat_mag : mag;
    return {sgn & (|m), m};
  endfunction

endpackage

// File: rtl/sm_acc_sat.sv
// Combinational clamp of a MAC result into the accumulate-operand range,
// flagging overflow and folding -0 to +0.
module sm_acc_sat
  import mac_pkg::*;
#(
  parameter int OUT_W = 19,
  parameter int C_W   = OUT_W - 1
) (
  input  logic [OUT_W-1:0] i_mout,
  output logic [OUT_W-1:0] o_acc,
  output logic             o_ovf
);

  localparam int SGN = OUT_W - 1;

  logic                w_ovf;
  logic [SM_MAX_W-1:0] w_mag;
  logic [SM_MAX_W-1:0] w_sat;
  logic [SM_MAX_W:0]   w_res;
  logic                w_unused_hi;

  // Any magnitude bit the accumulate operand cannot carry means overflow.
  assign w_ovf = |i_mout[SGN-1:C_W-1];
  assign w_mag = SM_MAX_W'(i_mout[SGN-1:0]);
  assign w_sat = SM_MAX_W'({(C_W-1){1'b1}});
  assign w_res = sm_sat_canon(i_mout[SGN], w_ovf, w_mag, w_sat);

  assign o_acc       = {w_res[SM_MAX_W], w_res[SGN-1:0]};
  assign o_ovf       = w_ovf;
  assign w_unused_hi = ^w_res[SM_MAX_W-1:SGN];

endmodule

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: streams operand pairs into one en/done MAC, feeding
// each result back as the next accumulate operand, and returns the final sum.
module mac_dot_seq
  import mac_pkg::*;
#(
  parameter int A_BITWIDTH   = 8,
  parameter int B_BITWIDTH   = A_BITWIDTH,
  parameter int OUT_BITWIDTH = 19,
  parameter int C_BITWIDTH   = OUT_BITWIDTH - 1,
  parameter int LEN_W        = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [A_BITWIDTH-1:0]   in_a,
  input  logic [B_BITWIDTH-1:0]   in_b,
  output logic                    mac_en,
  output logic [A_BITWIDTH-1:0]   mac_a,
  output logic [B_BITWIDTH-1:0]   mac_b,
  output logic [C_BITWIDTH-1:0]   mac_c,
  input  logic [OUT_BITWIDTH-1:0] mac_mout,
  input  logic                    mac_done,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [OUT_BITWIDTH-1:0] res_data,
  output logic                    res_ovf
);

  state_e                  r_state;
  logic [LEN_W-1:0]        r_cnt;
  logic [OUT_BITWIDTH-1:0] r_acc;
  logic                    r_ovf;
  logic [A_BITWIDTH-1:0]   r_a;
  logic [B_BITWIDTH-1:0]   r_b;
  logic                    r_busy, r_in_ready, r_mac_en, r_res_valid;

  logic [OUT_BITWIDTH-1:0] w_acc_nxt;
  logic                    w_ovf_nxt;

  sm_acc_sat #(.OUT_W(OUT_BITWIDTH), .C_W(C_BITWIDTH)) u_sat (
    .i_mout (mac_mout),
    .o_acc  (w_acc_nxt),
    .o_ovf  (w_ovf_nxt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_mac_en    <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_cnt  <= len;
          r_acc  <= '0;
          r_ovf  <= 1'b0;
          r_busy <= 1'b1;
          if (len == '0) begin
            r_state     <= S_RESULT;
            r_res_valid <= 1'b1;
          end else begin
            r_state    <= S_FETCH;
            r_in_ready <= 1'b1;
          end
        end
        S_FETCH: if (in_valid) begin
          r_a        <= in_a;
          r_b        <= in_b;
          r_in_ready <= 1'b0;
          r_mac_en   <= 1'b1;
          r_state    <= S_ISSUE;
        end
        S_ISSUE: begin
          r_mac_en <= 1'b0;
          r_state  <= S_WAIT;
        end
        // Operands stay frozen here; the MAC reads data_c near the end.
        S_WAIT: if (mac_done) begin
          r_acc <= w_acc_nxt;
          r_ovf <= r_ovf | w_ovf_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == LEN_W'(1)) begin
            r_state     <= S_RESULT;
            r_res_valid <= 1'b1;
          end else begin
            r_state    <= S_FETCH;
            r_in_ready <= 1'b1;
          end
        end
        S_RESULT: if (res_ready) begin
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b0;
          r_mac_en    <= 1'b0;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign in_ready  = r_in_ready;
  assign mac_en    = r_mac_en;
  assign mac_a     = r_a;
  assign mac_b     = r_b;
  assign mac_c     = {r_acc[OUT_BITWIDTH-1], r_acc[C_BITWIDTH-2:0]};
  assign res_valid = r_res_valid;
  assign res_data  = r_acc;
  assign res_ovf   = r_ovf;

endmodule

// File: doc/mac_dot_seq.md
Name: mac_dot_seq

Overview:
Initiator/sequencer for the sign-magnitude MAC unit (en/done responder). It accepts a dot-product job of LEN operand pairs over a valid/ready stream and issues one MAC operation per pair. Each MAC result is fed back as the next accumulate operand, and the final sum is presented on a valid/ready result port. It sits between the operand buffer/DMA and one MAC instance.

Parameters:
A_BITWIDTH, 8, operand A width, sign-magnitude (MSB = sign)
B_BITWIDTH, A_BITWIDTH, operand B width, sign-magnitude
OUT_BITWIDTH, 19, MAC result / accumulator width, sign-magnitude
C_BITWIDTH, OUT_BITWIDTH-1, MAC accumulate-operand width, sign-magnitude
LEN_W, 8, width of job length field

Ports:
clk  in  1  clock
rstn  in  1  reset
start  in  1  job start pulse; sampled only in IDLE
len  in  LEN_W  number of pairs; sampled with start
busy  out  1  high in every state except IDLE
in_valid  in  1  operand pair valid
in_ready  out  1  operand pair accepted when in_valid && in_ready
in_a  in  A_BITWIDTH  operand A
in_b  in  B_BITWIDTH  operand B
mac_en  out  1  MAC start strobe
mac_a  out  A_BITWIDTH  MAC data_a
mac_b  out  B_BITWIDTH  MAC data_b
mac_c  out  C_BITWIDTH  MAC data_c (running sum)
mac_mout  in  OUT_BITWIDTH  MAC result
mac_done  in  1  MAC one-cycle completion pulse
res_valid  out  1  result valid; held until accepted
res_ready  in  1  result accepted when res_valid && res_ready
res_data  out  OUT_BITWIDTH  final sum, sign-magnitude
res_ovf  out  1  sticky saturation flag for the job

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous and active-low. All registers and outputs reset to 0, state resets to IDLE, and the accumulator resets to +0.
- States: IDLE, FETCH, ISSUE, WAIT, RESULT.
- IDLE:
  - start=1 and len!=0: latch len into the remaining counter, set acc=+0, clear ovf, go to FETCH.
  - start=1 and len==0: go to RESULT with res_data=0 and res_ovf=0. No MAC operation is issued.
- FETCH:
  - in_ready=1 only in this state.
  - On a handshake, register in_a/in_b into mac_a/mac_b and go to ISSUE.
  - in_valid low: stall in FETCH indefinitely.
- ISSUE: mac_en=1 for exactly this one cycle, then go to WAIT.
- WAIT:
  - mac_a, mac_b and mac_c are held stable from ISSUE until mac_done is seen, because the MAC samples data_c late.
  - On mac_done=1: load acc from mac_mout (saturation and canonicalisation rules below) and decrement the counter. Go to RESULT if the counter reaches 0, otherwise go to FETCH.
- RESULT:
  - res_valid=1, with res_data and res_ovf stable.
  - On res_ready, go to IDLE. res_valid drops in the next cycle.
- Handshake rules:
  - mac_en is never asserted in a cycle where mac_done=1.
  - At least 2 cycles separate mac_done from the next mac_en, which guarantees the MAC is back in IDLE with done cleared.
- Per-pair cost: 1 FETCH (if in_valid is already high) + 1 ISSUE + the MAC's en-to-done latency (4 cycles for the current MAC).
- mac_c is always {acc[OUT-1], acc[C-2:0]}.
- Saturation: if mac_mout has any magnitude bit at index C-1 or above set, acc magnitude becomes all ones in bits [C-2:0] with the upper bits zero, the sign is kept, and ovf is set. ovf stays set until the next job starts.
- Canonicalisation: a zero magnitude is always stored with sign 0, so -0 never reaches mac_c or res_data.
- start while busy: ignored.
- Reset mid-job: returns to IDLE immediately. No partial result is produced, and the MAC must be reset by the same rstn.

Decomposition:
- Shared package (mac_pkg): state encoding localparams, the sign-magnitude field index constants, and a function for saturate + canonicalise.
- One natural sub-module: sm_acc_sat, a combinational sign-magnitude saturate/canonicalise unit taking mac_mout and producing the next acc and the ovf bit.

Test Plan:
- len=1, a=8'h03 (+3), b=8'h85 (-5) -> one mac_en pulse; res_data=19'h4000F (-15), res_ovf=0.
- len=3, pairs (+2,+3), (-4,+1), (-1,+1) -> three mac_en pulses, each at least 2 cycles after the prior mac_done; res_data=19'h00001.
- len=0 with start -> no mac_en; res_valid asserts the next cycle with res_data=0 and res_ovf=0.
- len=9, every pair (8'h7F, 8'h7F) -> after the 9th pair res_data=19'h1FFFF and res_ovf=1. A following len=1 job with (+1,+1) gives res_ovf=0.
- len=1, a=8'h80 (-0), b=8'h05 -> res_data=19'h00000, never 19'h40000.
- Backpressure and reset:
  - in_valid low for 5 cycles stalls in FETCH with mac_en=0.
  - res_ready low for 10 cycles holds res_valid and res_data stable.
  - start pulses while busy have no effect.
  - rstn low during WAIT drives busy=0, res_valid=0 and mac_en=0 asynchronously.
